// File: rtl/alu_pkg.sv
// Shared ALU constants, select codes and scheduler state encoding.
// No logic of its own; the carry rule lives here so every user applies it identically.
// No flow control.
package alu_pkg;

    localparam int SEL_W  = 4;
    localparam int DATA_W = 16;

    localparam logic [SEL_W-1:0] SEL_ADD    = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_ADC    = 4'b0101;
    localparam logic [SEL_W-1:0] SEL_CLR_CY = 4'b1011;
    localparam logic [SEL_W-1:0] SEL_SET_CY = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic cy_next(input logic [SEL_W-1:0] sel,
                                     input logic alu_cy,
                                     input logic cur_cy);
        logic nxt;
        nxt = cur_cy;
        case (sel)
            SEL_ADD, SEL_ADC: nxt = alu_cy;
            SEL_CLR_CY:       nxt = 1'b0;
            SEL_SET_CY:       nxt = 1'b1;
            default:          nxt = cur_cy;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-requester round-robin arbiter (EX vs PC) with a one-bit preference pointer.
// Latency: grant is combinational from the requests; the pointer updates on completion.
// Backpressure: none; the caller only consults the grant while it is idle.
module alu_rr_arb (
    input  logic Clock,
    input  logic Reset_n,
    input  logic req_ex,
    input  logic req_pc,
    input  logic upd,
    input  logic served_pc,
    output logic gnt_ex,
    output logic gnt_pc
);

    logic prefer_ex;

    // Preference goes to whoever was not served last; EX wins out of reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            prefer_ex <= 1'b1;
        end else if (upd) begin
            prefer_ex <= served_pc;
        end
    end

    assign gnt_ex = req_ex & (~req_pc | prefer_ex);
    assign gnt_pc = req_pc & ~gnt_ex;

endmodule

// File: rtl/alu_sched.sv
// Shares one registered ALU between EX and PC requesters; owns the carry flag.
// Latency: Gnt to Done is 2+ALU_LAT cycles, one grant per 3+ALU_LAT cycles.
// Backpressure: requests are held until Done; ALU_SCHED_PERF_CNT_EN adds Ex_Cnt/Pc_Cnt.
module alu_sched #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 11,
    parameter int SEL_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Ex_Req,
    input  logic [SEL_W-1:0]  Ex_Sel,
    input  logic [DATA_W-1:0] Ex_A,
    input  logic [DATA_W-1:0] Ex_B,
    output logic              Ex_Gnt,
    output logic              Ex_Done,
    output logic [DATA_W-1:0] Ex_Result,
    input  logic              Pc_Req,
    input  logic [PC_W-1:0]   Pc_In,
    output logic              Pc_Gnt,
    output logic              Pc_Done,
    output logic [PC_W-1:0]   Pc_Next,
    output logic [SEL_W-1:0]  Alu_Sel,
    output logic [DATA_W-1:0] Alu_A,
    output logic [DATA_W-1:0] Alu_B,
    output logic              Alu_Cy_In,
    input  logic [DATA_W-1:0] Alu_Out,
    input  logic              Alu_Cy_Out,
    output logic              Cy_Flag,
`ifdef ALU_SCHED_PERF_CNT_EN
    output logic [15:0]       Ex_Cnt,
    output logic [15:0]       Pc_Cnt,
`endif
    output logic              Busy
);

    localparam logic [1:0] LAT_M1 = 2'(ALU_LAT - 1);

    alu_pkg::state_t   state_q;
    logic              owner_pc_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] res_q;
    logic              res_cy_q;
    logic              gnt_ex;
    logic              gnt_pc;
    logic              arb_upd;

    assign arb_upd   = (state_q == alu_pkg::ST_DONE);
    assign Busy      = (state_q != alu_pkg::ST_IDLE);
    assign Alu_Cy_In = Cy_Flag;

    alu_rr_arb u_arb (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .req_ex    (Ex_Req),
        .req_pc    (Pc_Req),
        .upd       (arb_upd),
        .served_pc (owner_pc_q),
        .gnt_ex    (gnt_ex),
        .gnt_pc    (gnt_pc)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= alu_pkg::ST_IDLE;
            owner_pc_q <= 1'b0;
            cnt_q      <= '0;
            res_q      <= '0;
            res_cy_q   <= 1'b0;
            Ex_Gnt     <= 1'b0;
            Ex_Done    <= 1'b0;
            Ex_Result  <= '0;
            Pc_Gnt     <= 1'b0;
            Pc_Done    <= 1'b0;
            Pc_Next    <= '0;
            Alu_Sel    <= '0;
            Alu_A      <= '0;
            Alu_B      <= '0;
            Cy_Flag    <= 1'b0;
`ifdef ALU_SCHED_PERF_CNT_EN
            Ex_Cnt     <= '0;
            Pc_Cnt     <= '0;
`endif
        end else begin
            Ex_Gnt  <= 1'b0;
            Pc_Gnt  <= 1'b0;
            Ex_Done <= 1'b0;
            Pc_Done <= 1'b0;
            case (state_q)
                alu_pkg::ST_IDLE: begin
                    // Operands are latched straight onto the ALU ports at grant.
                    if (gnt_ex) begin
                        Ex_Gnt     <= 1'b1;
                        owner_pc_q <= 1'b0;
                        Alu_Sel    <= Ex_Sel;
                        Alu_A      <= Ex_A;
                        Alu_B      <= Ex_B;
                        state_q    <= alu_pkg::ST_ISSUE;
                    end else if (gnt_pc) begin
                        Pc_Gnt     <= 1'b1;
                        owner_pc_q <= 1'b1;
                        Alu_Sel    <= alu_pkg::SEL_ADD;
                        Alu_A      <= {{(DATA_W-PC_W){1'b0}}, Pc_In};
                        Alu_B      <= {{(DATA_W-1){1'b0}}, 1'b1};
                        state_q    <= alu_pkg::ST_ISSUE;
                    end
                end
                alu_pkg::ST_ISSUE: begin
                    cnt_q   <= LAT_M1;
                    state_q <= alu_pkg::ST_WAIT;
                end
                alu_pkg::ST_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        res_q    <= Alu_Out;
                        res_cy_q <= Alu_Cy_Out;
                        state_q  <= alu_pkg::ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                alu_pkg::ST_DONE: begin
                    if (owner_pc_q) begin
                        Pc_Done <= 1'b1;
                        Pc_Next <= res_q[PC_W-1:0];
`ifdef ALU_SCHED_PERF_CNT_EN
                        Pc_Cnt  <= Pc_Cnt + 16'd1;
`endif
                    end else begin
                        Ex_Done   <= 1'b1;
                        Ex_Result <= res_q;
                        Cy_Flag   <= alu_pkg::cy_next(Alu_Sel, res_cy_q, Cy_Flag);
`ifdef ALU_SCHED_PERF_CNT_EN
                        Ex_Cnt    <= Ex_Cnt + 16'd1;
`endif
                    end
                    state_q <= alu_pkg::ST_IDLE;
                end
                default: state_q <= alu_pkg::ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized bench for alu_sched with a behavioural ALU and a transaction-level reference model.
module tb_alu_sched;
    import alu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Ex_Req, Pc_Req;
    logic [3:0]  Ex_Sel;
    logic [15:0] Ex_A, Ex_B;
    logic        Ex_Gnt, Ex_Done, Pc_Gnt, Pc_Done;
    logic [15:0] Ex_Result;
    logic [10:0] Pc_In, Pc_Next;
    logic [3:0]  Alu_Sel;
    logic [15:0] Alu_A, Alu_B, Alu_Out;
    logic        Alu_Cy_In, Alu_Cy_Out, Cy_Flag, Busy;
`ifdef ALU_SCHED_PERF_CNT_EN
    logic [15:0] Ex_Cnt, Pc_Cnt;
`endif

    always #5 Clock = ~Clock;

    alu_sched #(.DATA_W(16), .PC_W(11), .SEL_W(4), .ALU_LAT(1)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Ex_Req(Ex_Req), .Ex_Sel(Ex_Sel), .Ex_A(Ex_A), .Ex_B(Ex_B),
        .Ex_Gnt(Ex_Gnt), .Ex_Done(Ex_Done), .Ex_Result(Ex_Result),
        .Pc_Req(Pc_Req), .Pc_In(Pc_In), .Pc_Gnt(Pc_Gnt), .Pc_Done(Pc_Done), .Pc_Next(Pc_Next),
        .Alu_Sel(Alu_Sel), .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Cy_In(Alu_Cy_In),
        .Alu_Out(Alu_Out), .Alu_Cy_Out(Alu_Cy_Out), .Cy_Flag(Cy_Flag),
`ifdef ALU_SCHED_PERF_CNT_EN
        .Ex_Cnt(Ex_Cnt), .Pc_Cnt(Pc_Cnt),
`endif
        .Busy(Busy)
    );

    // Environment ALU: one registered stage, returns {carry, result}.
    function automatic logic [16:0] alu_f(input logic [3:0] sel, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        logic [16:0] r;
        case (sel)
            4'b0100: r = {1'b0, a} + {1'b0, b};
            4'b0101: r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            4'b0000: r = {1'b0, a & b};
            4'b0010: r = {1'b0, a ^ b};
            default: r = {a[15], a ^ ~b};
        endcase
        return r;
    endfunction

    always @(posedge Clock) {Alu_Cy_Out, Alu_Out} <= alu_f(Alu_Sel, Alu_A, Alu_B, Alu_Cy_In);

    // Reference model state at transaction level.
    logic        m_cy;
    logic [15:0] m_ex;
    logic [10:0] m_pc;
    logic        m_last_pc;
    int checks = 0;
    int failures = 0;

    function automatic logic cy_rule(input logic [3:0] sel, input logic alu_cy, input logic cur);
        if (sel == 4'b0100 || sel == 4'b0101) return alu_cy;
        if (sel == 4'b1011) return 1'b0;
        if (sel == 4'b1100) return 1'b1;
        return cur;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic wait_gnt(input bit is_pc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = is_pc ? Pc_Gnt : Ex_Gnt;
        end
        chk(is_pc ? "pc_gnt" : "ex_gnt", is_pc ? Pc_Gnt : Ex_Gnt, 1);
    endtask

    task automatic do_ex(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        bit ok;
        Ex_Sel = sel; Ex_A = a; Ex_B = b; Ex_Req = 1'b1;
        wait_gnt(1'b0, ok);
        Ex_Req = 1'b0;
        if (ok) begin
            chk("ex_issue_sel", Alu_Sel, sel);
            chk("ex_issue_a", Alu_A, a);
            chk("ex_issue_b", Alu_B, b);
            chk("ex_issue_cyin", Alu_Cy_In, m_cy);
            chk("ex_issue_busy", Busy, 1);
            r = alu_f(sel, a, b, m_cy);
            tick(); tick();
            chk("ex_early_done", Ex_Done, 0);
            tick();
            m_cy = cy_rule(sel, r[16], m_cy);
            m_ex = r[15:0];
            m_last_pc = 1'b0;
            chk("ex_done", Ex_Done, 1);
            chk("ex_result", Ex_Result, m_ex);
            chk("ex_cy_flag", Cy_Flag, m_cy);
            chk("ex_pc_hold", Pc_Next, m_pc);
            chk("ex_busy_idle", Busy, 0);
            tick();
            chk("ex_done_pulse", Ex_Done, 0);
        end
    endtask

    task automatic do_pc(input logic [10:0] pc);
        bit ok;
        Pc_In = pc; Pc_Req = 1'b1;
        wait_gnt(1'b1, ok);
        Pc_Req = 1'b0;
        if (ok) begin
            chk("pc_issue_sel", Alu_Sel, 4'b0100);
            chk("pc_issue_a", Alu_A, {5'd0, pc});
            chk("pc_issue_b", Alu_B, 16'd1);
            tick(); tick();
            chk("pc_early_done", Pc_Done, 0);
            tick();
            m_pc = pc + 11'd1;
            m_last_pc = 1'b1;
            chk("pc_done", Pc_Done, 1);
            chk("pc_next", Pc_Next, m_pc);
            chk("pc_cy_hold", Cy_Flag, m_cy);
            chk("pc_ex_hold", Ex_Result, m_ex);
            tick();
            chk("pc_done_pulse", Pc_Done, 0);
        end
    endtask

    task automatic contention();
        logic [15:0] ca, cb;
        logic [10:0] cp, cp1;
        int ng, nd, lows, prev;
        ca = 16'($urandom); cb = 16'($urandom); cp = 11'($urandom); cp1 = cp + 11'd1;
        ng = 0; nd = 0; lows = 0; prev = 0;
        Ex_Sel = 4'b0010; Ex_A = ca; Ex_B = cb; Pc_In = cp;
        Ex_Req = 1'b1; Pc_Req = 1'b1;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            tick();
            chk("rr_dbl_gnt", Ex_Gnt & Pc_Gnt, 0);
            if (Ex_Gnt | Pc_Gnt) begin
                chk("rr_order", Pc_Gnt, !m_last_pc);
                m_last_pc = Pc_Gnt;
                if (ng > 0) chk("rr_gnt_gap", c - prev, 4);
                prev = c;
                ng++;
                if (ng == 3) begin
                    Ex_Req = 1'b0; Pc_Req = 1'b0;
                end
            end
            if (ng >= 1 && ng <= 2 && !Busy) lows++;
            if (Ex_Done) begin chk("rr_ex_res", Ex_Result, ca ^ cb); nd++; end
            if (Pc_Done) begin chk("rr_pc_next", Pc_Next, cp1); nd++; end
        end
        m_ex = ca ^ cb; m_pc = cp1;
        chk("rr_rounds", nd, 3);
        chk("rr_busy_lows", lows, 2);
        chk("rr_cy_hold", Cy_Flag, m_cy);
        tick();
        chk("rr_no_grant_after_drop", Ex_Gnt | Pc_Gnt, 0);
    endtask

    task automatic reset_mid_op();
        bit ok;
        do_pc(11'h2A5);
        do_ex(SEL_SET_CY, 16'h1234, 16'h00FF);
        Ex_Sel = SEL_ADD; Ex_A = 16'hFFFF; Ex_B = 16'h0001; Ex_Req = 1'b1;
        wait_gnt(1'b0, ok);
        Ex_Req = 1'b0;
        tick();
        Reset_n = 1'b0;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_ex_result", Ex_Result, 0);
        chk("rst_pc_next", Pc_Next, 0);
        chk("rst_cy_flag", Cy_Flag, 0);
        chk("rst_alu_cy_in", Alu_Cy_In, 0);
        chk("rst_alu_a", Alu_A, 0);
        chk("rst_alu_sel", Alu_Sel, 0);
        m_cy = 1'b0; m_ex = '0; m_pc = '0; m_last_pc = 1'b1;
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_done", Ex_Done | Pc_Done, 0);
        end
        do_ex(SEL_ADD, 16'h00FF, 16'h0001);
    endtask

    initial begin
        Reset_n = 1'b0; Ex_Req = 1'b0; Pc_Req = 1'b0;
        Ex_Sel = '0; Ex_A = '0; Ex_B = '0; Pc_In = '0;
        m_cy = 1'b0; m_ex = '0; m_pc = '0; m_last_pc = 1'b1;
        repeat (3) tick();
        chk("reset_busy", Busy, 0);
        chk("reset_gnt", Ex_Gnt | Pc_Gnt, 0);
        chk("reset_done", Ex_Done | Pc_Done, 0);
        chk("reset_cy", Cy_Flag, 0);
        chk("reset_ex_result", Ex_Result, 0);
        chk("reset_pc_next", Pc_Next, 0);
        chk("reset_alu_b", Alu_B, 0);
        Reset_n = 1'b1;
        tick();

        do_ex(SEL_ADD, 16'hFFFF, 16'h0001);
        do_ex(SEL_ADC, 16'h0001, 16'h0001);
        do_pc(11'h7FF);
        contention();
        do_ex(SEL_SET_CY, 16'hA5A5, 16'h0F0F);
        do_ex(SEL_CLR_CY, 16'h1111, 16'h2222);
        do_ex(4'b1110, 16'h8001, 16'h0003);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_ex(4'($urandom), 16'($urandom), 16'($urandom));
            else
                do_pc(($urandom_range(0, 3) == 0) ? 11'h7FF : 11'($urandom));
        end

        reset_mid_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
